// File: rtl/vram_sram_arbiter.sv
// vram_sram_arbiter: alternating-priority arbiter between CA write and VGA read ports driving one async 16-bit SRAM
module vram_sram_arbiter #(
  parameter int AVN_AW = 18,
  parameter int AVN_DW = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ca_avn_write,
  input  logic [AVN_AW-1:0] ca_avn_address,
  input  logic [AVN_DW-1:0] ca_avn_writedata,
  output logic              ca_avn_waitrequest,
  input  logic              vga_avn_read,
  input  logic [AVN_AW-1:0] vga_avn_address,
  output logic              vga_avn_waitrequest,
  output logic [AVN_DW-1:0] vga_avn_readdata,
  output logic              vga_avn_readdatavalid,
  output logic [AVN_AW-1:0] sram_addr,
  output logic [AVN_DW-1:0] sram_dq_write,
  input  logic [AVN_DW-1:0] sram_dq_read,
  output logic              sram_dq_en,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic last_grant;
  logic grant_rd;
  logic grant_wr;
  always_comb begin
    grant_rd = state == IDLE && vga_avn_read && (!ca_avn_write || last_grant);
    grant_wr = state == IDLE && ca_avn_write && !grant_rd;
  end
  assign vga_avn_waitrequest = !grant_rd;
  assign ca_avn_waitrequest  = !grant_wr;
  // SRAM controls are loaded on grant so they are live exactly in the RD/WR cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state                 <= IDLE;
      last_grant            <= 1'b1;
      sram_addr             <= '0;
      sram_dq_write         <= '0;
      sram_dq_en            <= 1'b0;
      sram_ce_n             <= 1'b1;
      sram_oe_n             <= 1'b1;
      sram_we_n             <= 1'b1;
      sram_lb_n             <= 1'b1;
      sram_ub_n             <= 1'b1;
      vga_avn_readdata      <= '0;
      vga_avn_readdatavalid <= 1'b0;
    end else begin
      state                 <= grant_rd ? RD : grant_wr ? WR : IDLE;
      vga_avn_readdatavalid <= state == RD;
      if (state == RD) vga_avn_readdata <= sram_dq_read;
      sram_ce_n  <= !(grant_rd || grant_wr);
      sram_lb_n  <= !(grant_rd || grant_wr);
      sram_ub_n  <= !(grant_rd || grant_wr);
      sram_oe_n  <= !grant_rd;
      sram_we_n  <= !grant_wr;
      sram_dq_en <= grant_wr;
      if (grant_rd || grant_wr) last_grant <= grant_wr;
      if (grant_rd) sram_addr <= vga_avn_address;
      if (grant_wr) begin
        sram_addr     <= ca_avn_address;
        sram_dq_write <= ca_avn_writedata;
      end
    end
  end
endmodule

// File: tb/tb_vram_sram_arbiter.sv
// tb_vram_sram_arbiter: directed self-checking bench with a behavioural async SRAM model
module tb_vram_sram_arbiter;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ca_avn_write = 1'b0;
  logic [17:0] ca_avn_address = '0;
  logic [15:0] ca_avn_writedata = '0;
  logic        ca_avn_waitrequest;
  logic        vga_avn_read = 1'b0;
  logic [17:0] vga_avn_address = '0;
  logic        vga_avn_waitrequest;
  logic [15:0] vga_avn_readdata;
  logic        vga_avn_readdatavalid;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_write;
  logic [15:0] sram_dq_read;
  logic        sram_dq_en, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
  logic [5:0]  ctrl;
  logic [15:0] mem [0:(1<<18)-1];
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  logic conflict = 1'b0;

  localparam logic [5:0] C_IDLE = 6'b111110;
  localparam logic [5:0] C_RD   = 6'b001000;
  localparam logic [5:0] C_WR   = 6'b010001;

  vram_sram_arbiter dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .ca_avn_write(ca_avn_write), .ca_avn_address(ca_avn_address),
    .ca_avn_writedata(ca_avn_writedata), .ca_avn_waitrequest(ca_avn_waitrequest),
    .vga_avn_read(vga_avn_read), .vga_avn_address(vga_avn_address),
    .vga_avn_waitrequest(vga_avn_waitrequest), .vga_avn_readdata(vga_avn_readdata),
    .vga_avn_readdatavalid(vga_avn_readdatavalid),
    .sram_addr(sram_addr), .sram_dq_write(sram_dq_write), .sram_dq_read(sram_dq_read),
    .sram_dq_en(sram_dq_en), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  always #5 sys_clk = ~sys_clk;
  assign ctrl = {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_en};
  assign sram_dq_read = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  // async SRAM: a write lands when we_n releases at the end of the WR cycle
  always @(posedge sys_clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_en) mem[sram_addr] <= sram_dq_write;

  always @(negedge sys_clk) begin
    if (vga_avn_readdatavalid) vcount++;
    if (sram_dq_en && !sram_oe_n) conflict = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d);
    logic ok = 1'b0;
    ca_avn_write = 1'b1;
    ca_avn_address = a;
    ca_avn_writedata = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sys_clk);
      ok = !ca_avn_waitrequest;
    end
    if (!ok) chk("write_accept_timeout", 0, 1);
    tick();
    ca_avn_write = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a, output logic [15:0] d);
    logic ok = 1'b0;
    vga_avn_read = 1'b1;
    vga_avn_address = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge sys_clk);
      ok = !vga_avn_waitrequest;
    end
    if (!ok) chk("read_accept_timeout", 0, 1);
    tick();
    vga_avn_read = 1'b0;
    ok = 1'b0;
    d = 16'hxxxx;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge sys_clk);
      ok = vga_avn_readdatavalid;
      d = vga_avn_readdata;
    end
    if (!ok) chk("readdatavalid_timeout", 0, 1);
    tick();
  endtask

  initial begin
    logic [15:0] d;
    logic [1:0] vw [0:7];
    logic [1:0] cw [0:7];
    int vc0, cyc, t0, tl, n;
    for (int i = 0; i < 8; i++) begin
      vw[i] = (i % 4 == 0) ? 2'd0 : 2'd1;
      cw[i] = (i % 4 == 2) ? 2'd0 : 2'd1;
    end
    repeat (2) tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_ctrl", ctrl, C_IDLE);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_write", sram_dq_write, 0);
    chk("rst_readdata", vga_avn_readdata, 0);
    chk("rst_valid", vga_avn_readdatavalid, 0);
    tick();

    // single write
    ca_avn_write = 1'b1;
    ca_avn_address = 18'h00010;
    ca_avn_writedata = 16'hABCD;
    @(negedge sys_clk);
    chk("wr_T_wait", ca_avn_waitrequest, 0);
    tick();
    ca_avn_write = 1'b0;
    @(negedge sys_clk);
    chk("wr_T1_addr", sram_addr, 18'h00010);
    chk("wr_T1_ctrl", ctrl, C_WR);
    chk("wr_T1_dq", sram_dq_write, 16'hABCD);
    @(negedge sys_clk);
    chk("wr_T2_ctrl", ctrl, C_IDLE);
    chk("wr_mem", mem[18'h00010], 16'hABCD);
    tick();

    // single read
    vga_avn_read = 1'b1;
    vga_avn_address = 18'h00010;
    @(negedge sys_clk);
    chk("rd_T_wait", vga_avn_waitrequest, 0);
    tick();
    vga_avn_read = 1'b0;
    @(negedge sys_clk);
    chk("rd_T1_ctrl", ctrl, C_RD);
    chk("rd_T1_valid", vga_avn_readdatavalid, 0);
    @(negedge sys_clk);
    chk("rd_T2_valid", vga_avn_readdatavalid, 1);
    chk("rd_T2_data", vga_avn_readdata, 16'hABCD);
    @(negedge sys_clk);
    chk("rd_T3_valid", vga_avn_readdatavalid, 0);
    chk("rd_T3_hold", vga_avn_readdata, 16'hABCD);
    tick();

    // both ports requesting continuously right after reset: R, W, R, W
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    vc0 = vcount;
    vga_avn_read = 1'b1;
    vga_avn_address = 18'h00010;
    ca_avn_write = 1'b1;
    ca_avn_address = 18'h00020;
    ca_avn_writedata = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk($sformatf("both_vga_wait_%0d", i), vga_avn_waitrequest, vw[i]);
      chk($sformatf("both_ca_wait_%0d", i), ca_avn_waitrequest, cw[i]);
      tick();
    end
    vga_avn_read = 1'b0;
    ca_avn_write = 1'b0;
    repeat (3) tick();
    chk("both_valid_count", vcount - vc0, 2);
    chk("both_mem", mem[18'h00020], 16'h1234);
    chk("both_readdata", vga_avn_readdata, 16'hABCD);

    // stream 100 writes, vga idle
    n = 0; cyc = 0; t0 = 0; tl = 0;
    ca_avn_write = 1'b1;
    ca_avn_address = 18'd0;
    ca_avn_writedata = 16'h5000;
    while (n < 100 && cyc < 400) begin
      @(negedge sys_clk);
      if (!ca_avn_waitrequest) begin
        if (n == 0) t0 = cyc;
        tl = cyc;
        n++;
      end
      cyc++;
      tick();
      ca_avn_address = 18'(n);
      ca_avn_writedata = 16'h5000 + 16'(n);
      if (n == 100) ca_avn_write = 1'b0;
    end
    ca_avn_write = 1'b0;
    repeat (2) tick();
    chk("stream_count", n, 100);
    chk("stream_span", tl - t0, 198);
    for (int i = 0; i < 100; i++) chk($sformatf("stream_mem_%0d", i), mem[i], 16'h5000 + 16'(i));

    // reset during RD
    vc0 = vcount;
    vga_avn_read = 1'b1;
    vga_avn_address = 18'd5;
    @(negedge sys_clk);
    chk("rstrd_T_wait", vga_avn_waitrequest, 0);
    tick();
    vga_avn_read = 1'b0;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("rstrd_T1_ctrl", ctrl, C_RD);
    tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("rstrd_T2_ctrl", ctrl, C_IDLE);
    chk("rstrd_T2_valid", vga_avn_readdatavalid, 0);
    repeat (3) tick();
    chk("rstrd_no_valid", vcount - vc0, 0);
    do_read(18'd5, d);
    chk("rstrd_reread", d, 16'h5005);

    // reduced frame: alternating pattern, then read back everything
    for (int i = 0; i < 512; i++) do_write(18'(i), (i % 2 == 0) ? 16'h0FFF : 16'h0000);
    vc0 = vcount;
    for (int i = 0; i < 512; i++) begin
      do_read(18'(i), d);
      chk($sformatf("frame_rd_%0d", i), d, (i % 2 == 0) ? 16'h0FFF : 16'h0000);
    end
    tick();
    chk("frame_valid_count", vcount - vc0, 512);
    chk("dq_oe_conflict", conflict, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
